// File: rtl/digital_integrator_if.sv
// rtl/digital_integrator_if.sv - delta-in / sample-out stream interface for digital_integrator
//
// Purpose: groups the input delta handshake and the output sample handshake.
// Signals:
//   in_valid / in_ready / in_delta[DW]    upstream delta stream
//   out_valid / out_ready / out_data[AW]  reconstructed sample stream
// Modports:
//   master - the bench/upstream side (drives in_*, out_ready)
//   slave  - the integrator side (drives in_ready, out_valid, out_data)

interface digital_integrator_if #(
    parameter int DW = 8,
    parameter int AW = 16
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_delta;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_data;

    modport master (
        output in_valid,
        output in_delta,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_delta,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/digital_integrator.sv
// rtl/digital_integrator.sv - reconstructs absolute samples from signed deltas (y[n] = y[n-1] + d[n])
//
// Purpose: inverse of digital_diff on the decode side of the difference-coded path.
//   The first accepted sample after rst/clr is taken as an absolute seed; later
//   samples are added to the accumulator. Output stage is one sample deep and
//   out_data is the accumulator itself.
// Parameters: DW delta width, AW accumulator/out_data width (AW >= DW), CW counter width.
// Ports:
//   clk    clock, rising edge
//   rst    asynchronous active-high reset
//   clr    synchronous clear (acc, count, ovf, pending output; back to seed state)
//   bus    digital_integrator_if.slave (in_* delta stream, out_* sample stream)
//   ovf    sticky: an add exceeded the signed AW range since rst/clr
//   count  accepted-sample counter, saturating
// Build option: INTEG_SAT_EN - saturate the accumulator on overflow instead of wrapping.

module digital_integrator #(
    parameter int DW = 8,
    parameter int AW = 16,
    parameter int CW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    digital_integrator_if.slave  bus,
    output logic                 ovf,
    output logic [CW-1:0]        count
);

    localparam logic [0:0] ST_SEED = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]           state;
    logic signed [AW-1:0] acc;
    logic                 out_valid_q;

    logic signed [DW-1:0] delta_s;
    logic signed [AW:0]   delta_ext;
    logic signed [AW:0]   acc_ext;
    logic signed [AW:0]   sum;
    logic                 add_ovf;
    logic signed [AW-1:0] acc_add;
    logic                 accept;
    logic                 in_ready_c;

    // Deliberately no in_valid term: upstream may rely on in_ready alone.
    assign in_ready_c = !clr && (!out_valid_q || bus.out_ready);
    assign accept     = bus.in_valid && in_ready_c;

    // Signed size casts sign-extend; the extra top bit exposes overflow.
    assign delta_s   = bus.in_delta;
    assign delta_ext = (AW+1)'(delta_s);
    assign acc_ext   = (AW+1)'(acc);
    assign sum       = acc_ext + delta_ext;
    assign add_ovf   = sum[AW] ^ sum[AW-1];

    always_comb begin
        acc_add = sum[AW-1:0];
`ifdef INTEG_SAT_EN
        // Clamp toward the sign of the true (AW+1)-bit sum.
        if (add_ovf) begin
            acc_add = sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
        end
`else
        // Two's complement wrap modulo 2^AW: nothing to adjust.
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_SEED;
            acc         <= '0;
            out_valid_q <= 1'b0;
            ovf         <= 1'b0;
            count       <= '0;
        end else if (clr) begin
            // clr wins over any accept or output transfer this cycle.
            state       <= ST_SEED;
            acc         <= '0;
            out_valid_q <= 1'b0;
            ovf         <= 1'b0;
            count       <= '0;
        end else begin
            if (accept) begin
                if (state == ST_SEED) begin
                    // Seed has no predecessor: load absolute value, no add, ovf untouched.
                    acc   <= AW'(delta_s);
                    state <= ST_RUN;
                end else begin
                    acc <= acc_add;
                    if (add_ovf) begin
                        ovf <= 1'b1;
                    end
                end
                out_valid_q <= 1'b1;
                if (count != {CW{1'b1}}) begin
                    count <= count + CW'(1);
                end
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = acc;

endmodule

// File: tb/tb_digital_integrator.sv
// tb/tb_digital_integrator.sv - directed self-checking bench for digital_integrator

module tb_digital_integrator;

    localparam int DW = 8;
    localparam int AW = 16;
    localparam int CW = 16;
    localparam int N_RT = 1000;

    logic          clk;
    logic          rst;
    logic          clr;
    logic          ovf;
    logic [CW-1:0] count;

    int checks;
    int errors;

    digital_integrator_if #(.DW(DW), .AW(AW)) bus ();

    digital_integrator #(.DW(DW), .AW(AW), .CW(CW)) dut (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .bus   (bus.slave),
        .ovf   (ovf),
        .count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        bus.in_valid = 1'b0;
        step();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clr = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_delta = '0;
        bus.out_ready = 1'b1;
        #12;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data got %h want 0000", bus.out_data); end
        checks++; if (count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic [15:0] exp_data [4];
        logic [7:0]  deltas [4];
        deltas[0] = 8'd100; deltas[1] = 8'd5; deltas[2] = 8'hFD; deltas[3] = 8'd0;
        exp_data[0] = 16'd100; exp_data[1] = 16'd105; exp_data[2] = 16'd102; exp_data[3] = 16'd102;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_delta = deltas[i];
            step();
            checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp_data[i]) begin
                errors++; $display("FAIL basic_sample%0d got v=%b %h want v=1 %h", i, bus.out_valid, bus.out_data, exp_data[i]);
            end
        end
        bus.in_valid = 1'b0;
        checks++; if (count !== 16'd4) begin errors++; $display("FAIL basic_count got %0d want 4", count); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf got %b want 0", ovf); end
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got v=%b want 0", bus.out_valid); end
    endtask

    task automatic test_backpressure();
        do_clr();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_delta = 8'd7;
        step();
        checks++; if (bus.out_data !== 16'd7) begin errors++; $display("FAIL bp_seed got %h want 0007", bus.out_data); end
        bus.out_ready = 1'b0;
        bus.in_delta = 8'd1;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", bus.in_ready); end
        step();
        step();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'd7) begin
            errors++; $display("FAIL bp_hold got v=%b %h want v=1 0007", bus.out_valid, bus.out_data);
        end
        checks++; if (count !== 16'd1) begin errors++; $display("FAIL bp_count_hold got %0d want 1", count); end
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_release got %b want 1", bus.in_ready); end
        step();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'd8) begin
            errors++; $display("FAIL bp_release got v=%b %h want v=1 0008", bus.out_valid, bus.out_data);
        end
        checks++; if (count !== 16'd2) begin errors++; $display("FAIL bp_count got %0d want 2", count); end
        bus.in_valid = 1'b0;
        step();
    endtask

    task automatic test_overflow();
        do_clr();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_delta = 8'd127;
        step();
        for (int i = 0; i < 258; i++) begin
            step();
        end
        bus.in_valid = 1'b0;
`ifdef INTEG_SAT_EN
        checks++; if (bus.out_data !== 16'h7FFF) begin errors++; $display("FAIL ovf_data got %h want 7fff", bus.out_data); end
`else
        // 127 * 259 = 32893 wraps to 32893 - 65536 = -32643 = 0x807D
        checks++; if (bus.out_data !== 16'h807D) begin errors++; $display("FAIL ovf_data got %h want 807d", bus.out_data); end
`endif
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", ovf); end
        checks++; if (count !== 16'd259) begin errors++; $display("FAIL ovf_count got %0d want 259", count); end
    endtask

    task automatic test_clr_collision();
        // out_valid is still 1 from the last overflow sample.
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_delta = 8'd50;
        clr = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL clr_in_ready got %b want 0", bus.in_ready); end
        step();
        checks++; if (bus.out_valid !== 1'b0 || count !== 16'd0 || ovf !== 1'b0) begin
            errors++; $display("FAIL clr_state got v=%b count=%0d ovf=%b want v=0 count=0 ovf=0", bus.out_valid, count, ovf);
        end
        clr = 1'b0;
        bus.in_delta = 8'hEC;
        step();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'hFFEC) begin
            errors++; $display("FAIL clr_seed got v=%b %h want v=1 ffec", bus.out_valid, bus.out_data);
        end
        checks++; if (count !== 16'd1 || ovf !== 1'b0) begin
            errors++; $display("FAIL clr_seed_status got count=%0d ovf=%b want 1 0", count, ovf);
        end
    endtask

    task automatic test_async_reset();
        bus.in_delta = 8'd30;
        step();
        checks++; if (bus.out_data !== 16'd10) begin errors++; $display("FAIL arst_pre got %h want 000a", bus.out_data); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0000 || count !== 16'd0 || ovf !== 1'b0) begin
            errors++; $display("FAIL arst_values got v=%b %h count=%0d ovf=%b want 0 0000 0 0", bus.out_valid, bus.out_data, count, ovf);
        end
        rst = 1'b0;
        bus.in_delta = 8'd40;
        step();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'd40 || count !== 16'd1) begin
            errors++; $display("FAIL arst_seed got v=%b %h count=%0d want 1 0028 1", bus.out_valid, bus.out_data, count);
        end
        bus.in_delta = 8'hF6;
        step();
        checks++; if (bus.out_data !== 16'd30) begin errors++; $display("FAIL arst_run got %h want 001e", bus.out_data); end
        bus.in_valid = 1'b0;
        step();
    endtask

    task automatic test_round_trip();
        int          x [N_RT];
        logic [7:0]  d [N_RT];
        int          in_idx;
        int          out_idx;
        int          cycles;
        int          s;
        int          nx;
        logic [15:0] exp_v;
        do_clr();
        x[0] = int'($urandom_range(0, 255)) - 128;
        d[0] = 8'(x[0]);
        for (int i = 1; i < N_RT; i++) begin
            s  = int'($urandom_range(0, 254)) - 127;
            nx = x[i-1] + s;
            if (nx > 32767 || nx < -32768) nx = x[i-1] - s;
            x[i] = nx;
            d[i] = 8'(x[i] - x[i-1]);
        end
        in_idx = 0;
        out_idx = 0;
        cycles = 0;
        while (out_idx < N_RT && cycles < 20000) begin
            bus.in_valid  = (in_idx < N_RT);
            bus.in_delta  = (in_idx < N_RT) ? d[in_idx] : 8'd0;
            bus.out_ready = 1'($urandom_range(0, 1));
            #1;
            if (bus.out_valid && bus.out_ready) begin
                exp_v = 16'(x[out_idx]);
                checks++; if (bus.out_data !== exp_v) begin
                    errors++; $display("FAIL rt_sample%0d got %h want %h", out_idx, bus.out_data, exp_v);
                end
                out_idx++;
            end
            if (bus.in_valid && bus.in_ready) in_idx++;
            step();
            cycles++;
        end
        bus.in_valid = 1'b0;
        checks++; if (out_idx != N_RT) begin errors++; $display("FAIL rt_timeout got %0d samples want %0d", out_idx, N_RT); end
        checks++; if (count !== 16'(N_RT)) begin errors++; $display("FAIL rt_count got %0d want %0d", count, N_RT); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_overflow();
        test_clr_collision();
        test_async_reset();
        test_round_trip();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
